// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared widths and control-state type for the ARM pipeline control
package arm_pipe_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - RAW hazard comparator; HAZARD_FORWARDING_EN selects load-use-only detection
module hazard_detect #(
    parameter int REG_ADDR_W = arm_pipe_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    output logic                  hazard
);

    logic exe_hit;

    // ID operands that depend on the instruction currently in EXE
    assign exe_hit = exe_wb_en &&
                     ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));

`ifdef HAZARD_FORWARDING_EN
    // With forwarding only a load still in EXE cannot supply its result in time
    logic unused_mem_terms;
    assign unused_mem_terms = ^{mem_dest, mem_wb_en};
    assign hazard = exe_mem_r_en && exe_hit;
`else
    // Without forwarding any pending write in EXE or MEM blocks the ID read
    logic mem_hit;
    logic unused_load_flag;
    assign unused_load_flag = exe_mem_r_en;
    assign mem_hit = mem_wb_en &&
                     ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));
    assign hazard = exe_hit || mem_hit;
`endif

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline freeze/flush control with stall counters (HAZARD_FORWARDING_EN configures hazard_detect)
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = arm_pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = arm_pipe_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_freeze,
    output logic                  if_freeze,
    output logic                  id_freeze,
    output logic                  exe_freeze,
    output logic                  mem_freeze,
    output logic                  if_flush,
    output logic                  id_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    import arm_pipe_pkg::*;

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             hazard;
    logic             mem_stall;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    // A new access freezes in the cycle it appears; MEM_DONE releases while the old access is still visible
    assign mem_stall = ((state_q == RUN) && mem_req) || (state_q == MEM_BUSY);

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and prioritised freeze/flush: memory stall > branch flush > data hazard
    always_comb begin
        state_d    = state_q;
        pc_freeze  = 1'b0;
        if_freeze  = 1'b0;
        id_freeze  = 1'b0;
        exe_freeze = 1'b0;
        mem_freeze = 1'b0;
        if_flush   = 1'b0;
        id_flush   = 1'b0;

        case (state_q)
            RUN:      if (mem_req)   state_d = MEM_BUSY;
            MEM_BUSY: if (mem_ready) state_d = MEM_DONE;
            MEM_DONE: state_d = RUN;
            default:  state_d = RUN;
        endcase

        if (rst) begin
            pc_freeze = 1'b0;
        end else if (mem_stall) begin
            pc_freeze  = 1'b1;
            if_freeze  = 1'b1;
            id_freeze  = 1'b1;
            exe_freeze = 1'b1;
            mem_freeze = 1'b1;
        end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (hazard) begin
            pc_freeze = 1'b1;
            if_freeze = 1'b1;
            id_flush  = 1'b1;
        end
    end

    // Saturating count of frozen-PC cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (pc_freeze && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Saturating count of branch flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (if_flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        branch_taken, mem_req, mem_ready;
    logic        pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze;
    logic        if_flush, id_flush;
    logic [15:0] stall_cycles, flush_events;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {pc, if, id, exe, mem freeze, if_flush, id_flush}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_MEM  = 7'b1111100;
    localparam logic [6:0] C_BR   = 7'b0000011;
    localparam logic [6:0] C_HZ   = 7'b1100001;

    logic [6:0] ctl;
    assign ctl = {pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze, if_flush, id_flush};

    hazard_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_freeze    (pc_freeze),
        .if_freeze    (if_freeze),
        .id_freeze    (id_freeze),
        .exe_freeze   (exe_freeze),
        .mem_freeze   (mem_freeze),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        mem_req = 1'b1; branch_taken = 1'b1;
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
        step();
        n_checks++;
        if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events);
        end
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL reset_ctl_hold: got %b want %b", ctl, C_NONE); end
        apply_reset();
    endtask

    task automatic test_data_hazard();
        logic [6:0] exp_mem;
        apply_reset();
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        n_checks++;
        if (ctl !== (FWD ? C_NONE : C_HZ)) begin
            n_fail++; $display("FAIL exe_hazard: got %b want %b", ctl, FWD ? C_NONE : C_HZ);
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (stall_cycles !== (FWD ? 16'd0 : 16'd1)) begin
            n_fail++; $display("FAIL exe_hazard_cnt: got %0d want %0d", stall_cycles, FWD ? 0 : 1);
        end
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL hazard_release: got %b want %b", ctl, C_NONE); end
        // second operand hit on MEM destination
        id_src1 = 4'd1; id_src2 = 4'd5; id_two_src = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
        #1;
        exp_mem = FWD ? C_NONE : C_HZ;
        n_checks++;
        if (ctl !== exp_mem) begin n_fail++; $display("FAIL mem_src2_hazard: got %b want %b", ctl, exp_mem); end
        id_two_src = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL src2_unused: got %b want %b", ctl, C_NONE); end
        clear_inputs();
        id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b0; exe_mem_r_en = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL no_wb_en: got %b want %b", ctl, C_NONE); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        id_src2 = 4'd9; id_two_src = 1'b1; exe_dest = 4'd9; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_HZ) begin n_fail++; $display("FAIL load_use: got %b want %b", ctl, C_HZ); end
        step();
        clear_inputs();
        n_checks++;
        if (stall_cycles !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cycles); end
    endtask

    task automatic test_mem_stall();
        apply_reset();
        mem_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mem_ready = (c == 4);
            #1;
            n_checks++;
            if (ctl !== C_MEM) begin n_fail++; $display("FAIL mem_stall_c%0d: got %b want %b", c, ctl, C_MEM); end
            step();
        end
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL mem_done: got %b want %b", ctl, C_NONE); end
        step();
        mem_req = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE || stall_cycles !== 16'd5) begin
            n_fail++; $display("FAIL mem_back_run: got %b/%0d want %b/5", ctl, stall_cycles, C_NONE);
        end
    endtask

    task automatic test_min_access();
        apply_reset();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_MEM) begin n_fail++; $display("FAIL min_acc_c0: got %b want %b", ctl, C_MEM); end
        step();
        n_checks++;
        if (ctl !== C_MEM) begin n_fail++; $display("FAIL min_acc_c1: got %b want %b", ctl, C_MEM); end
        step();
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL min_acc_done: got %b want %b", ctl, C_NONE); end
        clear_inputs();
        step();
    endtask

    task automatic test_branch_priority();
        apply_reset();
        branch_taken = 1'b1;
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BR) begin n_fail++; $display("FAIL branch_over_hazard: got %b want %b", ctl, C_BR); end
        step();
        clear_inputs();
        n_checks++;
        if (flush_events !== 16'd1 || stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL branch_cnt: got %0d/%0d want 1/0", flush_events, stall_cycles);
        end
    endtask

    task automatic test_branch_in_mem();
        apply_reset();
        mem_req = 1'b1; branch_taken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_MEM) begin n_fail++; $display("FAIL br_mem_c0: got %b want %b", ctl, C_MEM); end
        step();
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_MEM) begin n_fail++; $display("FAIL br_mem_busy: got %b want %b", ctl, C_MEM); end
        step();
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_BR) begin n_fail++; $display("FAIL br_mem_done: got %b want %b", ctl, C_BR); end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (ctl !== C_NONE || flush_events !== 16'd1 || stall_cycles !== 16'd2) begin
            n_fail++;
            $display("FAIL br_mem_after: got %b/%0d/%0d want %b/1/2", ctl, flush_events, stall_cycles, C_NONE);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        id_src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        n_checks++;
        if (stall_cycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h want fffe", stall_cycles); end
        step();
        n_checks++;
        if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_max: got %h want ffff", stall_cycles); end
        repeat (3) step();
        n_checks++;
        if (stall_cycles !== 16'hFFFF || ctl !== C_HZ) begin
            n_fail++; $display("FAIL sat_hold: got %h/%b want ffff/%b", stall_cycles, ctl, C_HZ);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        mem_req = 1'b1;
        step();
        step();
        #1;
        n_checks++;
        if (ctl !== C_MEM || stall_cycles !== 16'd2) begin
            n_fail++; $display("FAIL busy_pre_rst: got %b/%0d want %b/2", ctl, stall_cycles, C_MEM);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_NONE || stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL busy_rst: got %b/%0d want %b/0", ctl, stall_cycles, C_NONE);
        end
        mem_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_NONE) begin n_fail++; $display("FAIL rst_to_run: got %b want %b", ctl, C_NONE); end
        step();
        n_checks++;
        if (ctl !== C_NONE || stall_cycles !== 16'd0) begin
            n_fail++; $display("FAIL run_after_rst: got %b/%0d want %b/0", ctl, stall_cycles, C_NONE);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_data_hazard();
        test_load_use();
        test_mem_stall();
        test_min_access();
        test_branch_priority();
        test_branch_in_mem();
        test_reset_mid_busy();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
